// File: rtl/stat_display_scheduler.sv
// Purpose : time-shares the single stat readout of the 7-segment display among
//           four stats, rotating on a fixed dwell, advancing on a button and
//           pre-empting the rotation to show any stat that newly drops low.
// Latency : all outputs registered; they follow the causing input by one cycle.
// Flow    : no backpressure; btn_next is a one-cycle pulse, hold a level.
// Ports   : clk, rst (sync, active-high); stat0..stat3 [5:0] stat values;
//           btn_next advance/acknowledge; hold freezes rotation;
//           stat_name [3:0] shown index+1; stat_value [5:0] saturated value;
//           state [3:0] per-stat low flags; alert high while an alert is shown.
module stat_display_scheduler #(
   parameter int DWELL_CYCLES = 50_000_000,
   parameter int ALERT_CYCLES = 150_000_000,
   parameter int LOW_THRESH   = 10,
   parameter int MAX_VALUE    = 50
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] stat0,
   input  logic [5:0] stat1,
   input  logic [5:0] stat2,
   input  logic [5:0] stat3,
   input  logic       btn_next,
   input  logic       hold,
   output logic [3:0] stat_name,
   output logic [5:0] stat_value,
   output logic [3:0] state,
   output logic       alert
);

   // One timer serves both dwell kinds, so it is sized for the longer one.
   localparam int TMAX = (DWELL_CYCLES > ALERT_CYCLES) ? DWELL_CYCLES : ALERT_CYCLES;
   localparam int TW   = $clog2(TMAX);
   localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL_CYCLES - 1);
   localparam logic [TW-1:0] ALERT_LAST = TW'(ALERT_CYCLES - 1);
   localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
   localparam logic [5:0]    THRESH_V   = 6'(LOW_THRESH);
   localparam logic [5:0]    MAX_V      = 6'(MAX_VALUE);

   typedef enum logic [1:0] {
      MODE_AUTO  = 2'd0,
      MODE_HOLD  = 2'd1,
      MODE_ALERT = 2'd2
   } mode_t;

   mode_t         mode, mode_n;
   logic [1:0]    idx, idx_n;
   logic [TW-1:0] timer, timer_n;
   logic [3:0]    low_q;
   logic [3:0]    pend, pend_n;

   logic [5:0]    stat_arr [4];
   logic [3:0]    low;
   logic [3:0]    avail;
   logic [3:0]    clr;
   logic [1:0]    first;
   logic [5:0]    sel;
   logic [5:0]    value_n;

   function automatic logic [1:0] lowest(input logic [3:0] v);
      if (v[0])      return 2'd0;
      else if (v[1]) return 2'd1;
      else if (v[2]) return 2'd2;
      else           return 2'd3;
   endfunction

   always_comb begin
      stat_arr[0] = stat0;
      stat_arr[1] = stat1;
      stat_arr[2] = stat2;
      stat_arr[3] = stat3;
   end

   always_comb begin
      low = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         low[i] = (stat_arr[i] < THRESH_V);
      end
   end

   // A rising low flag is usable in the same cycle it is detected so that the
   // alert shows one cycle after the stat drops; anything no longer low is
   // dropped from the pending set.
   assign avail = (pend | (low & ~low_q)) & low;
   assign first = lowest(avail);

   always_comb begin
      mode_n  = mode;
      idx_n   = idx;
      timer_n = timer;
      clr     = 4'b0000;
      case (mode)
         MODE_AUTO, MODE_HOLD: begin
            if (|avail) begin
               mode_n  = MODE_ALERT;
               idx_n   = first;
               timer_n = '0;
               clr     = 4'b0001 << first;
            end else if (btn_next) begin
               idx_n = idx + 2'd1;
               // In HOLD the dwell timer stays frozen; only the stat moves.
               if (mode == MODE_AUTO) timer_n = '0;
            end else if (mode == MODE_AUTO) begin
               if (hold) begin
                  mode_n = MODE_HOLD;
               end else if (timer == DWELL_LAST) begin
                  idx_n   = idx + 2'd1;
                  timer_n = '0;
               end else begin
                  timer_n = timer + TIMER_ONE;
               end
            end else if (!hold) begin
               mode_n = MODE_AUTO;
            end
         end
         MODE_ALERT: begin
            if ((timer == ALERT_LAST) || btn_next) begin
               timer_n = '0;
               if (|avail) begin
                  idx_n = first;
                  clr   = 4'b0001 << first;
               end else begin
                  mode_n = hold ? MODE_HOLD : MODE_AUTO;
                  idx_n  = idx + 2'd1;
               end
            end else begin
               timer_n = timer + TIMER_ONE;
            end
         end
         default: begin
            mode_n  = MODE_AUTO;
            idx_n   = 2'd0;
            timer_n = '0;
         end
      endcase
      pend_n = avail & ~clr;
   end

   assign sel     = stat_arr[idx_n];
   assign value_n = (sel > MAX_V) ? MAX_V : sel;

   always_ff @(posedge clk) begin
      if (rst) begin
         mode       <= MODE_AUTO;
         idx        <= 2'd0;
         timer      <= '0;
         low_q      <= 4'b0000;
         pend       <= 4'b0000;
         stat_name  <= 4'd1;
         stat_value <= 6'd0;
         state      <= 4'b0000;
         alert      <= 1'b0;
      end else begin
         mode       <= mode_n;
         idx        <= idx_n;
         timer      <= timer_n;
         low_q      <= low;
         pend       <= pend_n;
         stat_name  <= {2'b00, idx_n} + 4'd1;
         stat_value <= value_n;
         state      <= low;
         alert      <= (mode_n == MODE_ALERT);
      end
   end

endmodule

// File: tb/tb_stat_display_scheduler.sv
// Purpose : directed bench for stat_display_scheduler with a behavioural
//           reference model checked every cycle plus literal spot checks.
// Ports   : none (top-level bench).
module tb_stat_display_scheduler;

   localparam int DWELL  = 4;
   localparam int ALRT   = 6;
   localparam int THRESH = 10;
   localparam int MAXV   = 50;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] stat0, stat1, stat2, stat3;
   logic       btn_next, hold;
   logic [3:0] stat_name;
   logic [5:0] stat_value;
   logic [3:0] state;
   logic       alert;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   stat_display_scheduler #(
      .DWELL_CYCLES(DWELL),
      .ALERT_CYCLES(ALRT),
      .LOW_THRESH(THRESH),
      .MAX_VALUE(MAXV)
   ) dut (
      .clk(clk),
      .rst(rst),
      .stat0(stat0),
      .stat1(stat1),
      .stat2(stat2),
      .stat3(stat3),
      .btn_next(btn_next),
      .hold(hold),
      .stat_name(stat_name),
      .stat_value(stat_value),
      .state(state),
      .alert(alert)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Tracks which stat is on screen, how long it has been there, whether an
   // alert is showing or the rotation is frozen, and which stats await an alert.
   int m_cur   = 0;
   int m_age   = 0;
   bit m_alert = 0;
   bit m_frz   = 0;
   bit m_prev[4];
   bit m_pend[4];

   always @(posedge clk) begin
      int sv[4];
      bit lw[4];
      int first;
      int e_name, e_val, e_state, e_alert;
      sv[0] = int'(stat0); sv[1] = int'(stat1); sv[2] = int'(stat2); sv[3] = int'(stat3);
      for (int i = 0; i < 4; i++) lw[i] = (sv[i] < THRESH);
      if (rst) begin
         m_cur = 0; m_age = 0; m_alert = 0; m_frz = 0;
         for (int i = 0; i < 4; i++) begin m_prev[i] = 0; m_pend[i] = 0; end
         e_name = 1; e_val = 0; e_state = 0; e_alert = 0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (lw[i] && !m_prev[i]) m_pend[i] = 1;
            if (!lw[i]) m_pend[i] = 0;
         end
         first = -1;
         for (int i = 3; i >= 0; i--) if (m_pend[i]) first = i;
         if (m_alert) begin
            if (m_age == ALRT - 1 || btn_next) begin
               m_age = 0;
               if (first >= 0) begin
                  m_cur = first; m_pend[first] = 0;
               end else begin
                  m_alert = 0; m_frz = hold; m_cur = (m_cur + 1) % 4;
               end
            end else m_age++;
         end else if (first >= 0) begin
            m_alert = 1; m_frz = 0; m_cur = first; m_pend[first] = 0; m_age = 0;
         end else if (btn_next) begin
            m_cur = (m_cur + 1) % 4;
            if (!m_frz) m_age = 0;
         end else if (m_frz) begin
            if (!hold) m_frz = 0;
         end else if (hold) begin
            m_frz = 1;
         end else if (m_age == DWELL - 1) begin
            m_cur = (m_cur + 1) % 4; m_age = 0;
         end else m_age++;
         for (int i = 0; i < 4; i++) m_prev[i] = lw[i];
         e_name  = m_cur + 1;
         e_val   = (sv[m_cur] > MAXV) ? MAXV : sv[m_cur];
         e_state = 0;
         for (int i = 0; i < 4; i++) if (lw[i]) e_state += (1 << i);
         e_alert = m_alert ? 1 : 0;
      end
      #1;
      chk("model stat_name", 32'(stat_name), 32'(e_name));
      chk("model stat_value", 32'(stat_value), 32'(e_val));
      chk("model state", 32'(state), 32'(e_state));
      chk("model alert", 32'(alert), 32'(e_alert));
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_name(input int nm);
      int n = 0;
      while (stat_name !== 4'(nm) && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("wait stat_name", 32'(stat_name), 32'(nm));
   endtask

   int rot_vals[4] = '{20, 30, 40, 45};

   initial begin
      rst = 1'b1; stat0 = 6'd20; stat1 = 6'd30; stat2 = 6'd40; stat3 = 6'd45;
      btn_next = 1'b0; hold = 1'b0;
      tick(3);
      chk("reset stat_name", 32'(stat_name), 32'd1);
      chk("reset stat_value", 32'(stat_value), 32'd0);
      chk("reset state", 32'(state), 32'd0);
      chk("reset alert", 32'(alert), 32'd0);
      rst = 1'b0;

      // rotation: name changes every DWELL cycles
      for (int k = 1; k <= 16; k++) begin
         tick(1);
         chk("rot stat_name", 32'(stat_name), 32'(1 + ((k / 4) % 4)));
         chk("rot stat_value", 32'(stat_value), 32'(rot_vals[(k / 4) % 4]));
      end
      chk("rot alert", 32'(alert), 32'd0);

      // hold on name 2, button advances, release resumes
      tick(4);
      chk("pre-hold stat_name", 32'(stat_name), 32'd2);
      hold = 1'b1;
      tick(20);
      chk("hold stat_name", 32'(stat_name), 32'd2);
      btn_next = 1'b1;
      tick(1);
      btn_next = 1'b0;
      chk("hold btn stat_name", 32'(stat_name), 32'd3);
      hold = 1'b0;
      tick(6);
      chk("resume stat_name", 32'(stat_name), 32'd4);

      // single alert on stat3
      stat3 = 6'd12;
      wait_name(2);
      stat3 = 6'd5;
      tick(1);
      chk("alert1 stat_name", 32'(stat_name), 32'd4);
      chk("alert1 stat_value", 32'(stat_value), 32'd5);
      chk("alert1 alert", 32'(alert), 32'd1);
      chk("alert1 state", 32'(state), 32'b1000);
      tick(5);
      chk("alert1 late alert", 32'(alert), 32'd1);
      tick(1);
      chk("alert1 end alert", 32'(alert), 32'd0);
      chk("alert1 end stat_name", 32'(stat_name), 32'd1);

      // simultaneous alerts on stat0 and stat2
      stat3 = 6'd45;
      tick(1);
      stat0 = 6'd5; stat2 = 6'd5;
      tick(1);
      chk("dual first name", 32'(stat_name), 32'd1);
      chk("dual state", 32'(state), 32'b0101);
      tick(5);
      chk("dual first late", 32'(stat_name), 32'd1);
      tick(1);
      chk("dual second name", 32'(stat_name), 32'd3);
      chk("dual second alert", 32'(alert), 32'd1);
      tick(5);
      chk("dual second late", 32'(stat_name), 32'd3);
      tick(1);
      chk("dual end name", 32'(stat_name), 32'd4);
      chk("dual end alert", 32'(alert), 32'd0);
      chk("dual end value", 32'(stat_value), 32'd45);

      // acknowledge with btn_next
      stat0 = 6'd20; stat2 = 6'd40;
      tick(1);
      stat1 = 6'd3;
      tick(1);
      chk("ack alert on", 32'(alert), 32'd1);
      chk("ack stat_name", 32'(stat_name), 32'd2);
      tick(2);
      btn_next = 1'b1;
      tick(1);
      btn_next = 1'b0;
      chk("ack alert off", 32'(alert), 32'd0);
      chk("ack next name", 32'(stat_name), 32'd3);

      // stat2 goes low and recovers while stat0 alert is showing
      stat0 = 6'd5;
      tick(1);
      chk("recov alert on", 32'(alert), 32'd1);
      chk("recov stat_name", 32'(stat_name), 32'd1);
      tick(1);
      stat2 = 6'd5;
      tick(1);
      stat2 = 6'd40;
      tick(4);
      chk("recov alert off", 32'(alert), 32'd0);
      chk("recov next name", 32'(stat_name), 32'd2);
      chk("recov state", 32'(state), 32'b0011);
      tick(3);
      chk("recov no alert", 32'(alert), 32'd0);

      // saturation, then reset in the middle of an alert
      stat0 = 6'd20; stat1 = 6'd30; stat2 = 6'd63;
      wait_name(3);
      chk("sat stat_value", 32'(stat_value), 32'd50);
      stat0 = 6'd5;
      tick(1);
      chk("pre-rst alert", 32'(alert), 32'd1);
      tick(2);
      rst = 1'b1;
      tick(1);
      chk("rst alert", 32'(alert), 32'd0);
      chk("rst stat_name", 32'(stat_name), 32'd1);
      chk("rst state", 32'(state), 32'd0);
      rst = 1'b0;
      tick(1);
      chk("post-rst alert", 32'(alert), 32'd1);
      chk("post-rst value", 32'(stat_value), 32'd5);
      tick(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
